// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write/status bundle of the boot loader.
// master = byte source / system side, slave = imem_loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                start;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic                cpu_hold;
    logic                busy;
    logic                done;
    logic                error;
    logic [ADDR_WIDTH:0] word_count;

    modport master (
        output rx_data, rx_valid, start,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, word_count
    );

    modport slave (
        input  rx_data, rx_valid, start,
        output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream (len16, 4N data bytes, sum8) -> big-endian words in instruction RAM.
// Write issues one cycle after a word's 4th byte; no backpressure, one byte per cycle sustained.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [16:0]         CAPACITY = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WC_ONE   = 1;
    localparam logic [TW-1:0]       IDLE_MAX = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]       IDLE_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    logic [7:0]          len_hi;
    logic [15:0]         len;
    logic [1:0]          byte_cnt;
    logic [7:0]          csum;
    logic [23:0]         word_asm;
    logic [TW-1:0]       idle_cnt;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_hold_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [ADDR_WIDTH:0] word_count_q;

    logic [15:0] len_rx;
    logic        len_bad;
    logic        last_word;

    assign len_rx    = {len_hi, bus.rx_data};
    assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > CAPACITY);
    assign last_word = (17'(word_count_q) + 17'd1) == {1'b0, len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            csum         <= '0;
            word_asm     <= '0;
            idle_cnt     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // Bytes are ignored here; a start coinciding with a byte drops that byte.
                    if (bus.start) begin
                        state        <= S_LEN_HI;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        word_count_q <= '0;
                        byte_cnt     <= '0;
                        csum         <= '0;
                        idle_cnt     <= '0;
                        cpu_hold_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                default: begin
                    if (bus.rx_valid) begin
                        idle_cnt <= '0;
                        case (state)
                            S_LEN_HI: begin
                                len_hi <= bus.rx_data;
                                state  <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                len <= len_rx;
                                if (len_bad) begin
                                    state   <= S_ERR;
                                    error_q <= 1'b1;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                csum     <= csum + bus.rx_data;
                                byte_cnt <= byte_cnt + 2'd1;
                                word_asm <= {word_asm[15:0], bus.rx_data};
                                if (byte_cnt == 2'd3) begin
                                    mem_we_q     <= 1'b1;
                                    mem_wdata_q  <= {word_asm, bus.rx_data};
                                    mem_addr_q   <= 32'({word_count_q, 2'b00});
                                    word_count_q <= word_count_q + WC_ONE;
                                    if (last_word) begin
                                        state <= S_CHECK;
                                    end
                                end
                            end
                            S_CHECK: begin
                                busy_q <= 1'b0;
                                if (bus.rx_data == csum) begin
                                    state      <= S_DONE;
                                    done_q     <= 1'b1;
                                    cpu_hold_q <= 1'b0;
                                end else begin
                                    state   <= S_ERR;
                                    error_q <= 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (idle_cnt == IDLE_MAX) begin
                        // Stream went silent: abort, any partial word is dropped, CPU stays held.
                        state   <= S_ERR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU's instruction memory. Receives a framed program image as a byte stream from the UART receiver, assembles big-endian 32-bit instruction words, and writes them into the writable instruction RAM at consecutive word addresses. It holds the CPU stalled while the image is in flight. It validates the image length and checksum, and reports completion or failure.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-index width of the instruction RAM; capacity 2^ADDR_WIDTH words (byte address bits [ADDR_WIDTH+1:2]).
- TIMEOUT, 50000, number of consecutive cycles without rx_valid, while loading, after which the load aborts.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle; may be asserted on consecutive cycles.
- start  in  1  one-cycle pulse that begins a load.
- mem_we  out  1  instruction RAM write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write; always word-aligned; bits [1:0] = 0.
- mem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  stalls the CPU (PC frozen) while high.
- busy  out  1  high in LEN_HI, LEN_LO, DATA and CHECK.
- done  out  1  sticky; the last load completed successfully.
- error  out  1  sticky; the last load aborted.
- word_count  out  ADDR_WIDTH+1  number of words written in the current or last load.

## Operation
- Frame format:
  - 2 length bytes N, big-endian, counted in words.
  - 4N data bytes, MSB-first per word.
  - 1 checksum byte, equal to the 8-bit modulo-256 sum of the data bytes only.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
- IDLE / DONE / ERR + start -> LEN_HI. On this transition:
  - clear done, error and word_count;
  - clear the byte counter and the checksum accumulator;
  - set cpu_hold.
- start is ignored while busy.
- LEN_HI + rx_valid -> LEN_LO; latch N[15:8].
- LEN_LO + rx_valid -> latch N[7:0], then:
  - if N == 0 or N > 2^ADDR_WIDTH -> ERR;
  - otherwise -> DATA.
- DATA, each rx_valid:
  - shift the byte into the word assembler;
  - add the byte to the checksum;
  - advance the byte-in-word counter (0..3).
- On the 4th byte of a word:
  - register mem_wdata and mem_addr = {word index, 2'b00};
  - pulse mem_we on the next cycle;
  - increment word_count together with mem_we.
- DATA -> CHECK when the 4th byte of word N-1 is accepted. The state advances without a stall; the final mem_we pulse issues during the first CHECK cycle.
- CHECK + rx_valid:
  - byte == checksum -> DONE; done = 1, cpu_hold = 0;
  - otherwise -> ERR; error = 1, cpu_hold stays 1.
- Timeout counter:
  - cleared on every rx_valid and on start;
  - counts only in busy states.
  - On the TIMEOUT-th consecutive idle cycle -> ERR. A partial word is discarded; no write.
- ERR keeps cpu_hold high (a partial image must not execute) until the next start or reset.
- Words already written before an error remain in the RAM.
- Bytes arriving in IDLE, DONE or ERR are ignored.
- A start pulse coinciding with rx_valid: the state transition wins and the byte is dropped.

## Timing
- Reset values (asynchronous, immediate): state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, busy 0, done 0, error 0, word_count 0. All counters and accumulators are 0.
- Reset mid-load aborts with no further writes. A write pulse already in flight is cancelled.
- start accepted at cycle t -> cpu_hold and busy high at cycle t+1.
- 4th byte of a word accepted at cycle t -> mem_we = 1 at cycle t+1 only, with addr/wdata stable in that cycle.
- Sustained throughput: one byte per cycle; one write every 4 cycles at best.
- Checksum byte accepted at cycle t -> done/error and cpu_hold updated at t+1.
- Length error: error at the cycle after the LEN_LO byte.
- Timeout: error = 1 exactly TIMEOUT cycles after the last rx_valid.
- Arithmetic widths:
  - checksum is 8-bit and wraps;
  - N is compared as 17-bit against 2^ADDR_WIDTH;
  - word index wraps never, because the length check prevents it.

## Test plan
- Good load: start, bytes 00 02 20 05 00 3C 8C A6 00 00 93 on consecutive cycles -> mem_we at addr 0x0 with 0x2005003C, then at addr 0x4 with 0x8CA60000; word_count = 2; done = 1; cpu_hold drops one cycle after 0x93.
- Bad checksum: same frame ending in 0x94 -> both writes occur; error = 1, done = 0, cpu_hold stays 1; a new start clears error.
- Length checks with ADDR_WIDTH = 8:
  - N = 0x0000 -> error at the cycle after the 2nd byte, no writes;
  - N = 0x0101 -> error, no writes;
  - N = 0x0100 -> accepted.
- Timeout with TIMEOUT = 16: frame 00 01 20 05 then silence -> error exactly 16 cycles after the byte 0x05; no mem_we.
- Start while busy and reset mid-load:
  - a start pulse during DATA is ignored and the load completes;
  - rst_n low during DATA -> all outputs 0 immediately;
  - after rst_n returns high, bytes are ignored until start.
- Spaced bytes: bytes arriving with gaps of 1..15 cycles and TIMEOUT = 16 -> same writes and done as the back-to-back case.
